// File: rtl/my_float_mul_if.sv
// Operand/control/result bundle between the Versat datapath and the float multiplier.
interface my_float_mul_if #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 32
);
   logic               run;
   logic               running;
   logic [DATA_W-1:0]  in0;
   logic [DATA_W-1:0]  in1;
   logic [DELAY_W-1:0] delay0;
   logic [DATA_W-1:0]  out0;

   modport master (output run, running, in0, in1, delay0, input out0);
   modport slave  (input run, running, in0, in1, delay0, output out0);
endinterface

// File: rtl/my_float_mul.sv
// Pipelined binary32 multiplier: unpack, mantissa product, normalise, round/pack.
// Result of operands sampled at edge k is on out0 after edge k+3.
module my_float_mul #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   my_float_mul_if.slave  bus
);

   logic [DELAY_W-1:0] cnt;
   logic               adv;
   logic               smp;

   assign adv = bus.running & ~bus.run;
   assign smp = adv & (cnt == '0);

   // stage 1 combinational unpack
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic        u_nan, u_inf, u_zero, u_sign;
   logic [9:0]  u_e;
   logic [23:0] u_ma, u_mb;

   always_comb begin
      ea     = bus.in0[30:23];
      eb     = bus.in1[30:23];
      fa     = bus.in0[22:0];
      fb     = bus.in1[22:0];
      nan_a  = (ea == 8'hFF) && (fa != 23'd0);
      nan_b  = (eb == 8'hFF) && (fb != 23'd0);
      inf_a  = (ea == 8'hFF) && (fa == 23'd0);
      inf_b  = (eb == 8'hFF) && (fb == 23'd0);
      zero_a = (ea == 8'h00);
      zero_b = (eb == 8'h00);
      u_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
      u_inf  = (inf_a | inf_b) & ~u_nan;
      u_zero = (zero_a | zero_b) & ~u_nan & ~u_inf;
      u_sign = bus.in0[31] ^ bus.in1[31];
      u_e    = {2'b00, ea} + {2'b00, eb} - 10'd127;
      u_ma   = {1'b1, fa};
      u_mb   = {1'b1, fb};
   end

   logic        v1, s1_sign, s1_nan, s1_inf, s1_zero;
   logic [9:0]  s1_e;
   logic [23:0] s1_ma, s1_mb;

   logic        v2, s2_sign, s2_nan, s2_inf, s2_zero;
   logic [9:0]  s2_e;
   logic [47:0] s2_prod;

   logic        v3, s3_sign, s3_nan, s3_inf, s3_zero;
   logic [9:0]  s3_e;
   logic [22:0] s3_frac;
   logic        s3_g, s3_s;

   // normalise the 48-bit product: leading one sits at bit 47 or bit 46
   logic [22:0] n_frac;
   logic        n_g, n_s;
   logic [9:0]  n_e;

   always_comb begin
      if (s2_prod[47]) begin
         n_frac = s2_prod[46:24];
         n_g    = s2_prod[23];
         n_s    = |s2_prod[22:0];
         n_e    = s2_e + 10'd1;
      end else begin
         n_frac = s2_prod[45:23];
         n_g    = s2_prod[22];
         n_s    = |s2_prod[21:0];
         n_e    = s2_e;
      end
   end

   // round to nearest even, then range-check the final exponent
   logic              round_up;
   logic [23:0]       rnd;
   logic [9:0]        e_f;
   logic [DATA_W-1:0] res;

   always_comb begin
      round_up = s3_g & (s3_s | s3_frac[0]);
      rnd      = {1'b0, s3_frac} + {23'd0, round_up};
      e_f      = s3_e + {9'd0, rnd[23]};
      if (s3_nan)
         res = 32'h7FC0_0000;
      else if (s3_inf)
         res = {s3_sign, 8'hFF, 23'd0};
      else if (s3_zero)
         res = {s3_sign, 31'd0};
      else if ($signed(e_f) >= $signed(10'd255))
         res = {s3_sign, 8'hFF, 23'd0};
      else if ($signed(e_f) <= $signed(10'd0))
         res = {s3_sign, 31'd0};
      else
         res = {s3_sign, e_f[7:0], rnd[22:0]};
   end

   always_ff @(posedge clk) begin
      if (rst || bus.run) begin
         cnt      <= rst ? '0 : bus.delay0;
         v1       <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_e     <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         v2       <= 1'b0;
         s2_sign  <= 1'b0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_e     <= '0;
         s2_prod  <= '0;
         v3       <= 1'b0;
         s3_sign  <= 1'b0;
         s3_nan   <= 1'b0;
         s3_inf   <= 1'b0;
         s3_zero  <= 1'b0;
         s3_e     <= '0;
         s3_frac  <= '0;
         s3_g     <= 1'b0;
         s3_s     <= 1'b0;
         bus.out0 <= '0;
      end else if (adv) begin
         if (cnt != '0)
            cnt <= cnt - DELAY_W'(1);
         v1      <= smp;
         s1_sign <= smp ? u_sign : 1'b0;
         s1_nan  <= smp ? u_nan  : 1'b0;
         s1_inf  <= smp ? u_inf  : 1'b0;
         s1_zero <= smp ? u_zero : 1'b0;
         s1_e    <= smp ? u_e    : 10'd0;
         s1_ma   <= smp ? u_ma   : 24'd0;
         s1_mb   <= smp ? u_mb   : 24'd0;

         v2      <= v1;
         s2_sign <= s1_sign;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
         s2_e    <= s1_e;
         s2_prod <= s1_ma * s1_mb;

         v3      <= v2;
         s3_sign <= s2_sign;
         s3_nan  <= s2_nan;
         s3_inf  <= s2_inf;
         s3_zero <= s2_zero;
         s3_e    <= n_e;
         s3_frac <= n_frac;
         s3_g    <= n_g;
         s3_s    <= n_s;

         bus.out0 <= v3 ? res : '0;
      end
   end

endmodule

// File: tb/tb_my_float_mul.sv
// Directed bench for my_float_mul with a queue scoreboard of in-flight expected products.
module tb_my_float_mul;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   my_float_mul_if #(.DATA_W(32), .DELAY_W(32)) bus ();

   my_float_mul #(.DATA_W(32), .DELAY_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_out;
   logic [31:0] cnt_m;

   task automatic flush_model();
      exp_q.delete();
      repeat (3) exp_q.push_back(32'h0);
      exp_out = 32'h0;
   endtask

   // One clock: drive controls/operands, advance the reference model, compare out0.
   task automatic step(input string tag, input logic r_rst, input logic r_run,
                       input logic r_running, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [31:0] dly);
      rst         = r_rst;
      bus.run     = r_run;
      bus.running = r_running;
      bus.in0     = a;
      bus.in1     = b;
      bus.delay0  = dly;
      @(posedge clk);
      #1;
      if (r_rst) begin
         cnt_m = 0;
         flush_model();
      end else if (r_run) begin
         cnt_m = dly;
         flush_model();
      end else if (r_running) begin
         exp_out = exp_q.pop_front();
         if (cnt_m != 0) begin
            cnt_m = cnt_m - 1;
            exp_q.push_back(32'h0);
         end else begin
            exp_q.push_back(exp);
         end
      end
      checks++;
      assert (bus.out0 === exp_out)
      else begin
         failures++;
         $error("FAIL %s out0=%h expected=%h", tag, bus.out0, exp_out);
      end
   endtask

   task automatic go(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
      step(tag, 1'b0, 1'b0, 1'b1, a, b, exp, 32'd0);
   endtask

   task automatic start(input string tag, input logic [31:0] dly);
      step(tag, 1'b0, 1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, dly);
   endtask

   task automatic drain(input string tag);
      repeat (3) go(tag, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      bus.run = 1'b0;
      bus.running = 1'b0;
      bus.in0 = '0;
      bus.in1 = '0;
      bus.delay0 = '0;
      cnt_m = 0;
      flush_model();

      // reset then idle with random operands
      step("reset", 1'b1, 1'b0, 1'b0, $urandom, $urandom, 32'h0, $urandom);
      repeat (10)
         step("idle", 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);

      // basic latency and back-to-back stream
      start("run0", 32'd0);
      go("lat_1p5x2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
      go("stream_2x2", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      go("stream_3x3", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
      go("stream_neg", 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
      drain("stream_drain");

      // delay skip with a mid-stream stall
      start("run2", 32'd2);
      go("skip1", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      go("skip2", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
      go("dly_first", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
      go("dly_second", 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000);
      step("stall1", 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'd0);
      step("stall2", 1'b0, 1'b0, 1'b0, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 32'd0);
      go("dly_resume", 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
      drain("dly_drain");

      // special operands
      start("run_sp", 32'd0);
      go("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
      go("overflow",   32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
      go("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
      go("subnormal",  32'h8000_0001, 32'h3F80_0000, 32'h8000_0000);
      go("neg_inf",    32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
      go("nan_in",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);

      // rounding cases, streamed straight after the specials
      go("sticky",     32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
      go("tie_even",   32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
      go("norm_shift", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
      drain("round_drain");

      // run while three products are in flight
      start("run_col", 32'd0);
      go("col_a", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
      go("col_b", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      go("col_c", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
      start("run_flush", 32'd0);
      drain("flush_no_stale");

      // reset mid-stream, after a long delay was loaded
      start("run5", 32'd5);
      go("pre_rst", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      step("rst_mid", 1'b1, 1'b0, 1'b1, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 32'd0);
      go("post_rst", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
      drain("post_rst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/my_float_mul.md
Name: my_float_mul

Overview:
- Pipelined IEEE-754 binary32 multiplier functional unit for the Versat datapath.
- Sits directly upstream of the float accumulator; together they form multiply-accumulate (dot-product / convolution) chains.
- Uses the same unit control protocol as the accumulator: run / running / delay0.
- out0 is wired to the accumulator's in0.

Parameters:
- DATA_W, 32, operand and result width; only 32 is supported (8-bit exponent, 23-bit fraction).
- DELAY_W, 32, width of delay0 and of the internal delay counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  one-cycle start pulse; loads the delay counter and flushes the pipeline.
- running  input  1  high while the accelerator is executing; low freezes the unit.
- in0  input  DATA_W  operand A (binary32).
- in1  input  DATA_W  operand B (binary32).
- delay0  input  DELAY_W  number of running cycles to skip after run before the first sample.
- out0  output  DATA_W  registered product (binary32).

Behaviour:
- Reset (rst=1 at an edge):
  - delay counter, all stage registers and out0 are cleared to 0.
  - rst overrides run and running.
  - Reset mid-operation discards in-flight products; out0=0 from the next cycle.
- run=1 at an edge:
  - counter <= delay0; stage-valid bits and stage data are cleared.
  - run wins over running in the same cycle.
  - out0 is cleared to 0.
- running=1, run=0, counter!=0:
  - counter decrements by 1.
  - Inputs are not sampled; a zero bubble advances through the stages.
- running=1, run=0, counter==0:
  - {in0,in1} are sampled every cycle.
  - The pipeline advances one stage per cycle.
- running=0: every register holds, including out0 and the counter (stall).
- Latency: operands sampled at edge k appear on out0 after edge k+3 (3 stages). Throughput is 1 product/cycle.
- Stage 1 (unpack):
  - sign = sa^sb.
  - Biased exponent sum e = ea+eb-127, kept as a 10-bit signed value.
  - Mantissas get the hidden 1 restored.
  - Special-case flags are computed here.
- Stage 2: 24x24 -> 48-bit unsigned mantissa product.
- Stage 3 (normalise, round, pack):
  - If product bit47 is set, shift right 1 and e+1.
  - Round to nearest, ties to even, using guard bit plus sticky OR of the remaining bits.
  - A rounding carry out of the mantissa increments e.
  - After rounding: e>=255 gives signed infinity; e<=0 gives signed zero (no subnormal outputs).
- Input rules:
  - Exponent 0 (zero or subnormal) is treated as signed zero.
  - Any NaN operand gives 0x7FC00000.
  - Inf times zero/subnormal gives 0x7FC00000.
  - Inf times finite nonzero gives signed infinity.
  - Zero times finite gives signed zero (sign = sa^sb).
- Special-case results bypass rounding but still obey the 3-cycle latency.
- Counter is unsigned.
  - delay0 = all ones gives 2^DELAY_W-1 skipped cycles, with no wrap.
  - The counter saturates at 0.

Test Plan:
1. Reset / idle:
   - Stimulus: rst=1 for 1 cycle, then idle for 10 cycles with random in0/in1, running=0.
   - Required: out0 == 0x00000000 throughout.
2. Basic latency, delay0=0:
   - Stimulus: run pulse, then running=1 with in0=0x3FC00000 (1.5), in1=0x40000000 (2.0) at sample edge k.
   - Required: out0 == 0x40400000 after edge k+3 and 0 before it; a back-to-back stream of 4 pairs yields 4 consecutive results.
3. Delay skip:
   - Stimulus: delay0=2, run, running=1, operand pairs changing every cycle.
   - Required: the first two pairs are ignored, the third pair's product appears 3 cycles after it is sampled, and out0=0 until then.
   - Also: drop running for 2 cycles mid-stream; out0 and the counter hold, and the sequence resumes unchanged.
4. Specials:
   - 0x7F800000 x 0x00000000 -> 0x7FC00000.
   - 0x7F000000 x 0x40000000 -> 0x7F800000.
   - 0x00800000 x 0x00800000 -> 0x00000000.
   - 0x80000001 x 0x3F800000 -> 0x80000000.
   - 0xFF800000 x 0x3F800000 -> 0xFF800000.
   - 0x7FC00001 x 0x3F800000 -> 0x7FC00000.
5. Rounding:
   - 0x3F800001 x 0x3F800001 -> 0x3F800002 (sticky).
   - 0x3F800001 x 0x3FC00000 -> 0x3FC00002 (tie to even).
   - 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE (normalise shift).
6. Control collisions:
   - Stimulus: assert run while 3 products are in flight with running=1.
   - Required: the pipeline is flushed, out0=0 next cycle, and no stale result emerges.
   - Stimulus: assert rst mid-stream.
   - Required: out0=0 next cycle and the counter is 0.
